// File: rtl/pipe_stage_buf.sv
// Stage-boundary skid FIFO: DEPTH-entry valid/ready buffer carrying an opaque
// payload bundle, frozen by one stall-vector bit and cleared by flush.
module pipe_stage_buf #(
    parameter int DATA_W    = 143,
    parameter int DEPTH     = 2,
    parameter int STALL_W   = 6,
    parameter int STAGE_IDX = 5
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       flush,
    input  logic [STALL_W-1:0]         stall,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [DATA_W-1:0]          in_data,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [DATA_W-1:0]          out_data,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH+1);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] mem_d [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              push, pop;
    logic              unused_stall;

    // Only bit STAGE_IDX of the stall vector matters here.
    assign unused_stall = ^stall;

    // in_ready depends on registered occupancy only, so a pop never frees a slot
    // for a push in the same cycle.
    assign in_ready  = (count_q != CNT_W'(DEPTH));
    assign out_valid = (count_q != '0);
    assign out_data  = out_valid ? mem_q[rd_ptr_q] : '0;
    assign count     = count_q;

    always_comb begin
        push     = in_valid && in_ready;
        pop      = out_valid && out_ready && !stall[STAGE_IDX];
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) begin
                mem_d[wr_ptr_q] = in_data;
                wr_ptr_d        = wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Payload storage needs no reset; stale entries are never visible.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

endmodule

// File: tb/tb_pipe_stage_buf.sv
// Bench for pipe_stage_buf: DEPTH=2 and DEPTH=4 instances share stimulus and
// are each checked every cycle against a queue model, plus directed literals.
module tb_pipe_stage_buf;

    localparam int DW = 143;

    logic          clk;
    logic          reset_n;
    logic          flush;
    logic [5:0]    stall;
    logic          in_valid;
    logic [DW-1:0] in_data;
    logic          out_ready;

    logic          in_ready2, out_valid2;
    logic [DW-1:0] out_data2;
    logic [1:0]    count2;
    logic          in_ready4, out_valid4;
    logic [DW-1:0] out_data4;
    logic [2:0]    count4;

    int n_tests = 0;
    int n_fail  = 0;

    logic [DW-1:0] q2[$];
    logic [DW-1:0] q4[$];

    pipe_stage_buf #(.DATA_W(DW), .DEPTH(2), .STALL_W(6), .STAGE_IDX(5)) dut2 (
        .clk(clk), .reset_n(reset_n), .flush(flush), .stall(stall),
        .in_valid(in_valid), .in_ready(in_ready2), .in_data(in_data),
        .out_valid(out_valid2), .out_ready(out_ready), .out_data(out_data2),
        .count(count2)
    );

    pipe_stage_buf #(.DATA_W(DW), .DEPTH(4), .STALL_W(6), .STAGE_IDX(5)) dut4 (
        .clk(clk), .reset_n(reset_n), .flush(flush), .stall(stall),
        .in_valid(in_valid), .in_ready(in_ready4), .in_data(in_data),
        .out_valid(out_valid4), .out_ready(out_ready), .out_data(out_data4),
        .count(count4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference model: a FIFO of payloads with capacity DEPTH.
    always @(posedge clk) begin
        if (!reset_n || flush) begin
            q2.delete();
            q4.delete();
        end else begin
            automatic bit pop2  = (q2.size() != 0) && out_ready && !stall[5];
            automatic bit push2 = in_valid && (q2.size() != 2);
            automatic bit pop4  = (q4.size() != 0) && out_ready && !stall[5];
            automatic bit push4 = in_valid && (q4.size() != 4);
            if (pop2)  void'(q2.pop_front());
            if (push2) q2.push_back(in_data);
            if (pop4)  void'(q4.pop_front());
            if (push4) q4.push_back(in_data);
        end
    end

    always @(negedge clk) begin
        chk("d2_count",     DW'(count2),     DW'(q2.size()));
        chk("d2_out_valid", DW'(out_valid2), DW'(q2.size() != 0));
        chk("d2_in_ready",  DW'(in_ready2),  DW'(q2.size() != 2));
        chk("d2_out_data",  out_data2,       (q2.size() != 0) ? q2[0] : '0);
        chk("d2_count_max", DW'(count2 <= 2'd2), DW'(1));
        chk("d4_count",     DW'(count4),     DW'(q4.size()));
        chk("d4_out_valid", DW'(out_valid4), DW'(q4.size() != 0));
        chk("d4_in_ready",  DW'(in_ready4),  DW'(q4.size() != 4));
        chk("d4_out_data",  out_data4,       (q4.size() != 0) ? q4[0] : '0);
        chk("d4_count_max", DW'(count4 <= 3'd4), DW'(1));
    end

    // Drive one cycle's inputs just after a falling edge, return at the next one.
    task automatic step(input logic iv, input logic [DW-1:0] d, input logic ordy,
                        input logic [5:0] st, input logic fl);
        #1;
        in_valid  = iv;
        in_data   = d;
        out_ready = ordy;
        stall     = st;
        flush     = fl;
        @(negedge clk);
    endtask

    logic [DW-1:0] va, vb, vc, big;
    logic [159:0]  rnd;

    initial begin
        reset_n = 1'b0; flush = 1'b0; stall = '0;
        in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
        va = DW'(16'hAAAA); vb = DW'(16'hBBBB); vc = DW'(16'hCCCC);
        big = DW'(36'h1_0000_0001);
        @(negedge clk);
        step(0, '0, 0, '0, 0);
        reset_n = 1'b1;
        chk("rst_out_valid", DW'(out_valid2), DW'(0));
        chk("rst_out_data",  out_data2, '0);
        chk("rst_in_ready",  DW'(in_ready2), DW'(1));
        chk("rst_count",     DW'(count2), DW'(0));

        step(1, big, 1, '0, 0);
        chk("lat_valid", DW'(out_valid2), DW'(1));
        chk("lat_data",  out_data2, big);
        step(0, '0, 1, '0, 0);
        chk("drain_valid", DW'(out_valid2), DW'(0));
        chk("drain_data",  out_data2, '0);
        chk("drain_count", DW'(count2), DW'(0));

        for (int i = 1; i <= 8; i++) begin
            step(1, DW'(i), 1, '0, 0);
            chk("stream_data",  out_data2, DW'(i));
            chk("stream_count", DW'(count2), DW'(1));
        end
        step(0, '0, 1, '0, 0);

        step(1, va, 1, 6'b100000, 0);
        step(1, vb, 1, 6'b100000, 0);
        chk("stall_count",    DW'(count2), DW'(2));
        chk("stall_in_ready", DW'(in_ready2), DW'(0));
        step(1, vc, 1, 6'b100000, 0);
        chk("stall_hold", out_data2, va);
        step(1, vc, 1, 6'b011111, 0);
        chk("fullpop_count", DW'(count2), DW'(1));
        chk("fullpop_head",  out_data2, vb);
        step(1, vc, 1, '0, 0);
        chk("after_stall_head", out_data2, vc);
        step(0, '0, 1, '0, 0);
        chk("after_stall_empty", DW'(count2), DW'(0));

        step(1, va, 0, '0, 0);
        step(1, vb, 0, '0, 0);
        step(1, vc, 1, '0, 1);
        chk("flush_count",    DW'(count2), DW'(0));
        chk("flush_valid",    DW'(out_valid2), DW'(0));
        chk("flush_data",     out_data2, '0);
        chk("flush_in_ready", DW'(in_ready2), DW'(1));
        step(0, '0, 1, '0, 0);
        chk("flush_no_store", DW'(count2), DW'(0));

        step(1, va, 0, '0, 0);
        step(1, vb, 0, '0, 0);
        #1;
        in_valid = 1'b0;
        reset_n  = 1'b0;
        #2;
        chk("sync_rst_hold", DW'(count2), DW'(2));
        @(negedge clk);
        chk("sync_rst_count",    DW'(count2), DW'(0));
        chk("sync_rst_in_ready", DW'(in_ready2), DW'(1));
        #1;
        reset_n = 1'b1;

        // Varying out_ready keeps DEPTH=4 occupancy moving through the pointer wrap.
        for (int i = 0; i < 13; i++)
            step(1, DW'(100 + i), (i % 3) != 0, '0, 0);
        for (int i = 0; i < 5; i++)
            step(0, '0, 1, '0, 0);
        chk("wrap_drained", DW'(count4), DW'(0));

        for (int i = 0; i < 2000; i++) begin
            rnd = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
            reset_n = ($urandom_range(0, 99) != 0);
            step($urandom_range(0, 3) != 0, rnd[DW-1:0], $urandom_range(0, 3) != 0,
                 {($urandom_range(0, 3) == 0), 5'($urandom())},
                 $urandom_range(0, 99) < 3);
        end
        reset_n = 1'b1;
        step(0, '0, 1, '0, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
